logic2_net: RTL and testbench
=============================

// Module: logic2_net
// PURPOSE
//  Gate-level reference network (4 inputs, 10 internal nets, 2 outputs) with
//  built-in single-net stuck-at fault injection. Used as the golden/faulty
//  device in functional fault-testing campaigns.
//  Sits between the test-vector generator and the response comparator.
//  Outputs are registered; one vector per clock.
// PARAMETERS
//  NUM_SITES  17  fault-site codes 0..16; code 0 = fault-free
//  SEL_W      5   width of fault_sel
// PORTS
//  clk          in   1  rising-edge clock
//  rst_n        in   1  reset; one clock, asynchronous, active-low
//  in_valid     in   1  a/b/c/e/fault_sel/fault_val valid this cycle
//  a,b,c,e      in   1  primary inputs (one port each)
//  fault_sel    in   5  fault-site code (table below)
//  fault_val    in   1  stuck-at value for the selected site
//  out_valid    out  1  y/z hold a new result
//  y,z          out  1  primary outputs (registered)
//  fault_active out  1  registered; 1 when the sampled fault_sel is in 1..16
// BEHAVIOUR
//  Netlist (evaluated combinationally from current inputs). Every net first
//  passes its site mux: net' = (fault_sel==code) ? fault_val : net.
//   d=a&b  f=~(b|c)  g=c^e  h=d|f  j=~(f&g)  k=a^e
//   w=h&j  x=g|k  p=w^x  q=~(j&k)  y=p|d  z=q&g
//  Downstream nets use the muxed (post-fault) value of every fanin.
//  Site codes: 0 none, 1 a, 2 b, 3 c, 4 d, 5 e, 6 f, 7 g, 8 h, 9 j,
//   10 k, 11 w, 12 x, 13 p, 14 q, 15 y, 16 z; codes 17..31 = none.
//  Only one site is faulted per vector; fault_sel/fault_val apply per vector.
//  Timing: on a rising edge with in_valid=1: y,z <= net result;
//   fault_active <= (1<=fault_sel<=16); out_valid <= 1.
//   Latency is one cycle.
//  in_valid=0 at an edge: out_valid <= 0; y, z and fault_active hold.
//  Back-to-back vectors at full rate are supported; no backpressure.
//  rst_n low (async): y=0, z=0, out_valid=0, fault_active=0 immediately.
//   These outputs stay at 0 while rst_n is low. The first update is the
//   first edge after rst_n is released.
//  Reset asserted mid-stream: the vector sampled in that cycle is discarded.
//  X on an unused input is not propagated when that input is faulted.
// STRUCTURE
//  Package logic2_pkg: localparam site codes (SITE_NONE..SITE_Z).
//   Also holds SEL_W and NUM_SITES.
//  Sub-module fault_site_mux (net_in, code, fault_sel, fault_val -> net_out).
//   Instantiate once per site (16 instances).
//  Top: combinational netlist + output register stage.
// TESTING
//  1. Reset: hold rst_n=0 -> y=0,z=0,out_valid=0.
//     Release -> outputs still 0 until the first valid vector.
//  2. Fault-free: sel=0, abce=0000 -> y=1,z=0 next cycle.
//     sel=0, abce=1101 -> y=1,z=1.
//  3. Internal fault: abce=1101, sel=7 (g), val=0 -> y=1, z=0,
//     fault_active=1.
//  4. Input fault: abce=0000, sel=1 (a), val=1 -> y=0, z=0.
//  5. Output faults: any vector, sel=15 val=0 -> y=0;
//     sel=16 val=1 -> z=1; sel=20 -> fault-free result, fault_active=0.
//  6. Exhaustive: all 16 input vectors x all 34 (site,val) pairs,
//     back-to-back with in_valid gaps. Compare against a behavioural model
//     of the netlist. Verify hold on in_valid=0.
//     Assert reset mid-stream -> immediate clear.

Source files
------------

// File: rtl/logic2_pkg.sv
// Site codes and widths shared by the fault-injectable reference netlist.
package logic2_pkg;

  localparam int NUM_SITES = 17;
  localparam int SEL_W     = 5;

  localparam logic [SEL_W-1:0] SITE_NONE = SEL_W'(0);
  localparam logic [SEL_W-1:0] SITE_A    = SEL_W'(1);
  localparam logic [SEL_W-1:0] SITE_B    = SEL_W'(2);
  localparam logic [SEL_W-1:0] SITE_C    = SEL_W'(3);
  localparam logic [SEL_W-1:0] SITE_D    = SEL_W'(4);
  localparam logic [SEL_W-1:0] SITE_E    = SEL_W'(5);
  localparam logic [SEL_W-1:0] SITE_F    = SEL_W'(6);
  localparam logic [SEL_W-1:0] SITE_G    = SEL_W'(7);
  localparam logic [SEL_W-1:0] SITE_H    = SEL_W'(8);
  localparam logic [SEL_W-1:0] SITE_J    = SEL_W'(9);
  localparam logic [SEL_W-1:0] SITE_K    = SEL_W'(10);
  localparam logic [SEL_W-1:0] SITE_W    = SEL_W'(11);
  localparam logic [SEL_W-1:0] SITE_X    = SEL_W'(12);
  localparam logic [SEL_W-1:0] SITE_P    = SEL_W'(13);
  localparam logic [SEL_W-1:0] SITE_Q    = SEL_W'(14);
  localparam logic [SEL_W-1:0] SITE_Y    = SEL_W'(15);
  localparam logic [SEL_W-1:0] SITE_Z    = SEL_W'(16);

  // Codes above SITE_Z are treated as fault-free.
  function automatic logic is_fault_site(input logic [SEL_W-1:0] sel);
    return (sel >= SITE_A) && (sel <= SITE_Z);
  endfunction

endpackage

// File: rtl/logic2_net_fault_site_mux.sv
// One stuck-at injection point: replaces its net with fault_val when selected.
module fault_site_mux
  import logic2_pkg::*;
(
  input  logic             net_i,
  input  logic [SEL_W-1:0] code_i,
  input  logic [SEL_W-1:0] fault_sel_i,
  input  logic             fault_val_i,
  output logic             net_o
);

  // A selected net never looks at net_i, so an X there cannot leak through.
  assign net_o = (fault_sel_i == code_i) ? fault_val_i : net_i;

endmodule

// File: rtl/logic2_net.sv
// Reference 4-input gate network with single-site stuck-at injection and a
// one-cycle registered output stage.
module logic2_net
  import logic2_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             e,
  input  logic [SEL_W-1:0] fault_sel,
  input  logic             fault_val,
  output logic             out_valid,
  output logic             y,
  output logic             z,
  output logic             fault_active
);

  // Nets are grouped by logic depth so every vector only feeds later levels.
  localparam logic [3:0][SEL_W-1:0] L0_CODE = {SITE_E, SITE_C, SITE_B, SITE_A};
  localparam logic [3:0][SEL_W-1:0] L1_CODE = {SITE_K, SITE_G, SITE_F, SITE_D};
  localparam logic [1:0][SEL_W-1:0] L2_CODE = {SITE_J, SITE_H};
  localparam logic [2:0][SEL_W-1:0] L3_CODE = {SITE_Q, SITE_X, SITE_W};
  localparam logic [1:0][SEL_W-1:0] L4_CODE = {SITE_Z, SITE_P};

  logic [3:0] l0_raw, l0_m;
  logic [3:0] l1_raw, l1_m;
  logic [1:0] l2_raw, l2_m;
  logic [2:0] l3_raw, l3_m;
  logic [1:0] l4_raw, l4_m;
  logic       y_raw, y_m;

  logic a_m, b_m, c_m, e_m, d_m, f_m, g_m, k_m, h_m, j_m, w_m, x_m, q_m, p_m, z_m;

  assign l0_raw = {e, c, b, a};
  for (genvar i = 0; i < 4; i++) begin : g_l0
    fault_site_mux u_mux (
      .net_i(l0_raw[i]), .code_i(L0_CODE[i]), .fault_sel_i(fault_sel),
      .fault_val_i(fault_val), .net_o(l0_m[i])
    );
  end
  assign {e_m, c_m, b_m, a_m} = l0_m;

  assign l1_raw = {a_m ^ e_m, c_m ^ e_m, ~(b_m | c_m), a_m & b_m};
  for (genvar i = 0; i < 4; i++) begin : g_l1
    fault_site_mux u_mux (
      .net_i(l1_raw[i]), .code_i(L1_CODE[i]), .fault_sel_i(fault_sel),
      .fault_val_i(fault_val), .net_o(l1_m[i])
    );
  end
  assign {k_m, g_m, f_m, d_m} = l1_m;

  assign l2_raw = {~(f_m & g_m), d_m | f_m};
  for (genvar i = 0; i < 2; i++) begin : g_l2
    fault_site_mux u_mux (
      .net_i(l2_raw[i]), .code_i(L2_CODE[i]), .fault_sel_i(fault_sel),
      .fault_val_i(fault_val), .net_o(l2_m[i])
    );
  end
  assign {j_m, h_m} = l2_m;

  assign l3_raw = {~(j_m & k_m), g_m | k_m, h_m & j_m};
  for (genvar i = 0; i < 3; i++) begin : g_l3
    fault_site_mux u_mux (
      .net_i(l3_raw[i]), .code_i(L3_CODE[i]), .fault_sel_i(fault_sel),
      .fault_val_i(fault_val), .net_o(l3_m[i])
    );
  end
  assign {q_m, x_m, w_m} = l3_m;

  assign l4_raw = {q_m & g_m, w_m ^ x_m};
  for (genvar i = 0; i < 2; i++) begin : g_l4
    fault_site_mux u_mux (
      .net_i(l4_raw[i]), .code_i(L4_CODE[i]), .fault_sel_i(fault_sel),
      .fault_val_i(fault_val), .net_o(l4_m[i])
    );
  end
  assign {z_m, p_m} = l4_m;

  assign y_raw = p_m | d_m;
  fault_site_mux u_mux_y (
    .net_i(y_raw), .code_i(SITE_Y), .fault_sel_i(fault_sel),
    .fault_val_i(fault_val), .net_o(y_m)
  );

  logic y_q, y_d, z_q, z_d, fa_q, fa_d, vld_q, vld_d;

  // Results only move on a valid vector; gaps just drop out_valid.
  always_comb begin
    y_d   = y_q;
    z_d   = z_q;
    fa_d  = fa_q;
    vld_d = in_valid;
    if (in_valid) begin
      y_d  = y_m;
      z_d  = z_m;
      fa_d = is_fault_site(fault_sel);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q   <= 1'b0;
      z_q   <= 1'b0;
      fa_q  <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      z_q   <= z_d;
      fa_q  <= fa_d;
      vld_q <= vld_d;
    end
  end

  assign y            = y_q;
  assign z            = z_q;
  assign fault_active = fa_q;
  assign out_valid    = vld_q;

endmodule

// File: tb/tb_logic2_net.sv
// Self-checking bench for logic2_net: directed table, exhaustive site sweep,
// random vectors with gaps, and reset corner cases.
module tb_logic2_net;
  import logic2_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             a = 1'b0, b = 1'b0, c = 1'b0, e = 1'b0;
  logic [SEL_W-1:0] fault_sel = '0;
  logic             fault_val = 1'b0;
  logic             out_valid, y, z, fault_active;

  int n_chk  = 0;
  int n_fail = 0;
  logic hy = 1'b0, hz = 1'b0, hfa = 1'b0;

  typedef struct {
    logic [3:0] abce;
    logic [4:0] sel;
    logic       val;
    logic       y;
    logic       z;
    logic       fa;
  } vec_t;

  always #5 clk = ~clk;

  logic2_net dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a), .b(b), .c(c), .e(e),
    .fault_sel(fault_sel), .fault_val(fault_val),
    .out_valid(out_valid), .y(y), .z(z), .fault_active(fault_active)
  );

  function automatic logic flt(input logic v, input int code, input int sel, input logic val);
    return (sel == code) ? val : v;
  endfunction

  // Reference: nets evaluated in the order the netlist lists them, each one
  // overridden by the stuck value when it is the selected site.
  function automatic logic [2:0] model(input logic [3:0] abce, input int sel, input logic val);
    logic ma, mb, mc, me, md, mf, mg, mh, mj, mk, mw, mx, mp, mq, my, mz;
    ma = flt(abce[3], 1, sel, val);
    mb = flt(abce[2], 2, sel, val);
    mc = flt(abce[1], 3, sel, val);
    me = flt(abce[0], 5, sel, val);
    md = flt(ma & mb, 4, sel, val);
    mf = flt(~(mb | mc), 6, sel, val);
    mg = flt(mc ^ me, 7, sel, val);
    mh = flt(md | mf, 8, sel, val);
    mj = flt(~(mf & mg), 9, sel, val);
    mk = flt(ma ^ me, 10, sel, val);
    mw = flt(mh & mj, 11, sel, val);
    mx = flt(mg | mk, 12, sel, val);
    mp = flt(mw ^ mx, 13, sel, val);
    mq = flt(~(mj & mk), 14, sel, val);
    my = flt(mp | md, 15, sel, val);
    mz = flt(mq & mg, 16, sel, val);
    return {my, mz, logic'(sel >= 1 && sel <= 16)};
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] abce, input logic [4:0] sel, input logic val);
    @(negedge clk);
    in_valid  = v;
    {a, b, c, e} = abce;
    fault_sel = sel;
    fault_val = val;
  endtask

  task automatic run_vec(input string nm, input logic [3:0] abce, input logic [4:0] sel, input logic val);
    logic [2:0] m;
    m = model(abce, int'(sel), val);
    drive(1'b1, abce, sel, val);
    @(posedge clk); #1;
    chk({nm, ".out_valid"}, {7'd0, out_valid}, 8'd1);
    chk({nm, ".y"}, {7'd0, y}, {7'd0, m[2]});
    chk({nm, ".z"}, {7'd0, z}, {7'd0, m[1]});
    chk({nm, ".fa"}, {7'd0, fault_active}, {7'd0, m[0]});
    {hy, hz, hfa} = m;
  endtask

  task automatic run_gap();
    drive(1'b0, 4'($urandom), 5'($urandom), 1'($urandom));
    @(posedge clk); #1;
    chk("gap.out_valid", {7'd0, out_valid}, 8'd0);
    chk("gap.hold", {5'd0, y, z, fault_active}, {5'd0, hy, hz, hfa});
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, {4'd0, out_valid, y, z, fault_active}, 8'd0);
  endtask

  initial begin
    vec_t tbl[10];
    tbl[0] = '{4'b0000, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{4'b1101, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{4'b1101, 5'd7,  1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{4'b0000, 5'd1,  1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{4'b1101, 5'd15, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{4'b0000, 5'd16, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[6] = '{4'b1101, 5'd20, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{4'b0000, 5'd31, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{4'b0000, 5'd17, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9] = '{4'b0000, 5'd9,  1'b0, 1'b0, 1'b0, 1'b1};

    // Power-on reset, held across edges, then released with no vector.
    #2 rst_n = 1'b0;
    #1 chk_zero("reset.async");
    repeat (2) @(posedge clk);
    #1 chk_zero("reset.held");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_zero("reset.released_idle");

    for (int i = 0; i < 10; i++) begin
      drive(1'b1, tbl[i].abce, tbl[i].sel, tbl[i].val);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d.vld", i), {7'd0, out_valid}, 8'd1);
      chk($sformatf("tbl%0d.yzf", i), {5'd0, y, z, fault_active},
          {5'd0, tbl[i].y, tbl[i].z, tbl[i].fa});
      {hy, hz, hfa} = {tbl[i].y, tbl[i].z, tbl[i].fa};
    end
    run_gap();

    // Every input vector against every (site, stuck value), with random gaps.
    for (int v = 0; v < 16; v++)
      for (int s = 0; s < NUM_SITES; s++)
        for (int fv = 0; fv < 2; fv++) begin
          run_vec($sformatf("ex_v%0d_s%0d_f%0d", v, s, fv), 4'(v), 5'(s), 1'(fv));
          if ($urandom_range(0, 3) == 0) run_gap();
        end

    for (int i = 0; i < 300; i++) begin
      run_vec("rand", 4'($urandom), 5'($urandom), 1'($urandom));
      if ($urandom_range(0, 4) == 0) run_gap();
    end

    // Reset mid-stream: the vector presented in that cycle must be dropped.
    run_vec("pre_rst", 4'b1101, 5'd0, 1'b0);
    drive(1'b1, 4'b1101, 5'd16, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_zero("midrst.async");
    @(posedge clk); #1;
    chk_zero("midrst.discard");
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk_zero("midrst.released");
    {hy, hz, hfa} = 3'b000;
    run_vec("post_rst", 4'b0000, 5'd0, 1'b0);
    run_gap();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
